// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory read arbiter.
//   arb_state_e : S_IDLE (arbitrate), S_ADDR (AR handshake), S_DATA (R beats)
//   REQ_ICACHE / REQ_DCACHE : requester indices, NUM_REQ : requester count
package mem_arb_pkg;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: cache-side and memory-side read channel signals of the arbiter.
//   req_arvalid/araddr/arlen  : per-requester AR request (master -> arbiter)
//   req_arready/rvalid/rdata  : per-requester handshake and beat data (arbiter -> master)
//   mem_ar*/mem_rready        : memory AR channel and R ready (arbiter -> memory)
//   mem_arready/rvalid/rdata/rid : memory responses (memory -> arbiter)
//   grant/busy/protocol_err   : status
//   modport slave  : the arbiter's view
//   modport master : the view of whoever drives requesters and memory
interface mem_read_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
);
    logic [NUM_REQ-1:0]                 req_arvalid;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_arlen;
    logic [NUM_REQ-1:0]                 req_arready;
    logic [NUM_REQ-1:0]                 req_rvalid;
    logic [DATA_WIDTH-1:0]              req_rdata;
    logic                               mem_arvalid;
    logic [ADDR_WIDTH-1:0]              mem_araddr;
    logic [LEN_WIDTH-1:0]               mem_arlen;
    logic [3:0]                         mem_arid;
    logic                               mem_arready;
    logic                               mem_rvalid;
    logic [DATA_WIDTH-1:0]              mem_rdata;
    logic [3:0]                         mem_rid;
    logic                               mem_rready;
    logic                               grant;
    logic                               busy;
    logic                               protocol_err;

    modport slave (
        input  req_arvalid, req_araddr, req_arlen, mem_arready, mem_rvalid, mem_rdata, mem_rid,
        output req_arready, req_rvalid, req_rdata, mem_arvalid, mem_araddr, mem_arlen, mem_arid,
               mem_rready, grant, busy, protocol_err
    );

    modport master (
        output req_arvalid, req_araddr, req_arlen, mem_arready, mem_rvalid, mem_rdata, mem_rid,
        input  req_arready, req_rvalid, req_rdata, mem_arvalid, mem_araddr, mem_arlen, mem_arid,
               mem_rready, grant, busy, protocol_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin winner select.
//   i_valid      : request valids, bit n = requester n
//   i_last_grant : requester that owned the previous burst
//   o_grant      : winning requester index (meaningful only when any i_valid is set)
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic       o_grant
);

    // A tie goes to whoever did not win last; otherwise the lone requester wins.
    assign o_grant = (&i_valid) ? ~i_last_grant : i_valid[1];

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one memory AR/R channel between I-cache (0) and D-cache (1) refills.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : mem_read_arbiter_if.slave, requester and memory channels plus status outputs
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int LEN_WIDTH  = 4,
    parameter int MAX_BEATS  = 8
) (
    input logic               clk,
    input logic               rst,
    mem_read_arbiter_if.slave bus
);

    arb_state_e            r_state;
    logic                  r_grant;
    logic                  r_last;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat;

    logic                  w_win;
    logic                  w_any;
    logic [LEN_WIDTH-1:0]  w_len_in;
    logic                  w_in_bad;
    logic [LEN_WIDTH-1:0]  w_last_idx;
    logic                  w_beat;
    logic                  w_stray;
    logic                  w_id_err;
    logic                  w_err_evt;
    logic [1:0]            w_oh;

    rr_arbiter2 u_rr (
        .i_valid      (bus.req_arvalid),
        .i_last_grant (r_last),
        .o_grant      (w_win)
    );

    assign w_any    = |bus.req_arvalid;
    assign w_len_in = bus.req_arlen[w_win];
    assign w_in_bad = (w_len_in == '0) || (w_len_in > LEN_WIDTH'(MAX_BEATS));

    // Illegal lengths collapse to a single-beat burst so the channel is always released.
    assign w_last_idx = ((r_len == '0) || (r_len > LEN_WIDTH'(MAX_BEATS))) ? '0 : r_len - LEN_WIDTH'(1);

    assign w_beat    = (r_state == S_DATA) && bus.mem_rvalid;
    assign w_stray   = (r_state != S_DATA) && bus.mem_rvalid;
    assign w_id_err  = w_beat && (bus.mem_rid != bus.mem_arid);
    assign w_err_evt = w_stray || w_id_err || ((r_state == S_IDLE) && w_any && w_in_bad);
    assign w_oh      = r_grant ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            r_err <= r_err || w_err_evt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_addr  <= bus.req_araddr[w_win];
                        r_len   <= w_len_in;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.mem_arready) r_state <= S_DATA;
                end
                S_DATA: begin
                    // Compare before incrementing so the counter never wraps.
                    if (w_beat) begin
                        if (r_beat == w_last_idx) begin
                            r_state <= S_IDLE;
                            r_last  <= r_grant;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + LEN_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_arvalid  = (r_state == S_ADDR);
    assign bus.mem_araddr   = r_addr;
    assign bus.mem_arlen    = r_len;
    assign bus.mem_arid     = {3'b000, r_grant};
    assign bus.mem_rready   = (r_state == S_DATA);
    assign bus.req_arready  = ((r_state == S_ADDR) && bus.mem_arready) ? w_oh : 2'b00;
    assign bus.req_rvalid   = w_beat ? w_oh : 2'b00;
    assign bus.req_rdata    = bus.mem_rdata;
    assign bus.grant        = r_grant;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.protocol_err = r_err;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed self-checking bench for mem_read_arbiter.
module tb_mem_read_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_read_arbiter_if bus ();

    mem_read_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.req_arvalid = '0;
        bus.req_araddr  = '0;
        bus.req_arlen   = '0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rid     = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic request(input int g, input logic [25:0] addr, input logic [3:0] len);
        bus.req_arvalid[g] = 1'b1;
        bus.req_araddr[g]  = addr;
        bus.req_arlen[g]   = len;
    endtask

    // Starts one cycle after the grant edge; optional wait cycles before mem_arready.
    task automatic ar_phase(input int g, input logic [25:0] addr, input logic [3:0] len,
                            input int wait_cycles, input logic drop);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            bus.mem_arready = 1'b0;
            #1;
            chk("ar_wait_arvalid", 32'(bus.mem_arvalid), 32'd1);
            chk("ar_wait_arready", 32'(bus.req_arready), 32'd0);
        end
        @(negedge clk);
        bus.mem_arready = 1'b1;
        #1;
        chk("ar_arvalid", 32'(bus.mem_arvalid), 32'd1);
        chk("ar_araddr", 32'(bus.mem_araddr), 32'(addr));
        chk("ar_arlen", 32'(bus.mem_arlen), 32'(len));
        chk("ar_arid", 32'(bus.mem_arid), 32'(g));
        chk("ar_grant", 32'(bus.grant), 32'(g));
        chk("ar_busy", 32'(bus.busy), 32'd1);
        chk("ar_req_arready", 32'(bus.req_arready), 32'(oh(g)));
        @(posedge clk);
        #1;
        bus.mem_arready = 1'b0;
        if (drop) bus.req_arvalid[g] = 1'b0;
    endtask

    // Delivers n beats with the given rid, then checks the idle cycle that follows.
    task automatic data_phase(input int g, input int n, input logic [3:0] rid);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = 32'hA500_0000 + 32'(g * 256 + i);
            @(negedge clk);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = d;
            bus.mem_rid    = rid;
            #1;
            chk("dat_rvalid", 32'(bus.req_rvalid), 32'(oh(g)));
            chk("dat_rdata", bus.req_rdata, d);
            chk("dat_rready", 32'(bus.mem_rready), 32'd1);
            chk("dat_arready_low", 32'(bus.req_arready), 32'd0);
            chk("dat_arvalid_low", 32'(bus.mem_arvalid), 32'd0);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_rready", 32'(bus.mem_rready), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;

        // Reset state
        do_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_err", 32'(bus.protocol_err), 32'd0);
        chk("rst_arvalid", 32'(bus.mem_arvalid), 32'd0);
        chk("rst_rready", 32'(bus.mem_rready), 32'd0);
        chk("rst_araddr", 32'(bus.mem_araddr), 32'd0);
        chk("rst_arid", 32'(bus.mem_arid), 32'd0);

        // 1: req0 alone, len 4, mem_arready on the 2nd S_ADDR cycle
        @(negedge clk);
        request(0, 26'h100, 4'd4);
        #1;
        chk("t1_arvalid_lag", 32'(bus.mem_arvalid), 32'd0);
        ar_phase(0, 26'h100, 4'd4, 1, 1'b1);
        data_phase(0, 4, 4'd0);
        chk("t1_err", 32'(bus.protocol_err), 32'd0);

        // 2: simultaneous requests after reset, req0 first then req1
        do_reset();
        @(negedge clk);
        request(0, 26'h200, 4'd2);
        request(1, 26'h300, 4'd3);
        ar_phase(0, 26'h200, 4'd2, 0, 1'b1);
        data_phase(0, 2, 4'd0);
        ar_phase(1, 26'h300, 4'd3, 0, 1'b1);
        data_phase(1, 3, 4'd1);
        chk("t2_err", 32'(bus.protocol_err), 32'd0);

        // 3: both requesting continuously, grants alternate
        do_reset();
        @(negedge clk);
        request(0, 26'h1000, 4'd1);
        request(1, 26'h2000, 4'd1);
        for (int k = 0; k < 6; k++) begin
            ar_phase(k % 2, (k % 2 != 0) ? 26'h2000 : 26'h1000, 4'd1, 0, 1'b0);
            data_phase(k % 2, 1, 4'((k % 2)));
        end
        bus.req_arvalid = '0;

        // Longest legal burst: 8 beats, no error
        @(negedge clk);
        request(1, 26'h3F0, 4'd8);
        ar_phase(1, 26'h3F0, 4'd8, 0, 1'b1);
        data_phase(1, 8, 4'd1);
        chk("max_len_err", 32'(bus.protocol_err), 32'd0);

        // 5: reset after the 2nd of 4 beats, then a normal req1 burst
        do_reset();
        @(negedge clk);
        request(0, 26'h500, 4'd4);
        ar_phase(0, 26'h500, 4'd4, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b1;
            bus.mem_rid    = 4'd0;
            #1;
            chk("t5_beat", 32'(bus.req_rvalid), 32'd1);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_rready", 32'(bus.mem_rready), 32'd0);
        chk("t5_err", 32'(bus.protocol_err), 32'd0);
        request(1, 26'h040, 4'd2);
        ar_phase(1, 26'h040, 4'd2, 0, 1'b1);
        data_phase(1, 2, 4'd1);
        chk("t5_err_after", 32'(bus.protocol_err), 32'd0);

        // 4: stray beat in S_IDLE
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rid    = 4'd0;
        #1;
        chk("t4_no_rvalid", 32'(bus.req_rvalid), 32'd0);
        chk("t4_err_pre", 32'(bus.protocol_err), 32'd0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("t4_err_set", 32'(bus.protocol_err), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_err_sticky", 32'(bus.protocol_err), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);

        // 6: len 0 ends after a single beat and flags an error
        do_reset();
        @(negedge clk);
        request(0, 26'h600, 4'd0);
        ar_phase(0, 26'h600, 4'd0, 0, 1'b1);
        data_phase(0, 1, 4'd0);
        chk("t6_err", 32'(bus.protocol_err), 32'd1);

        // len above the maximum also collapses to one beat
        do_reset();
        @(negedge clk);
        request(1, 26'h700, 4'd9);
        ar_phase(1, 26'h700, 4'd9, 0, 1'b1);
        data_phase(1, 1, 4'd1);
        chk("len9_err", 32'(bus.protocol_err), 32'd1);

        // Wrong rid: beat still delivered, error raised
        do_reset();
        @(negedge clk);
        request(1, 26'h800, 4'd1);
        ar_phase(1, 26'h800, 4'd1, 0, 1'b1);
        chk("rid_err_pre", 32'(bus.protocol_err), 32'd0);
        data_phase(1, 1, 4'd0);
        chk("rid_err", 32'(bus.protocol_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
